// File: rtl/selector41_pkg.sv
// Shared types, sizes and the round-robin pick helper for the 4:1 selector arbiter.
package selector41_pkg;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned DATA_W = 4;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  // Result of one round-robin scan.
  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } rr_pick_t;

  // Scan ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first set request bit wins.
  // Iterating from the far end lets the nearest candidate overwrite the others.
  function automatic rr_pick_t rrPick(input logic [SEL_W-1:0] ptr,
                                      input logic [N_REQ-1:0] req);
    rr_pick_t         r;
    logic [SEL_W-1:0] cand;
    r = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        r.found = 1'b1;
        r.idx   = cand;
      end
    end
    return r;
  endfunction

  function automatic logic [N_REQ-1:0] oneHot(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/selector41_rr_arbiter_if.sv
// Requester/consumer bundle of the round-robin selector arbiter.
//   iReq, iC0..iC3 : requests and per-requester data (driven by the sources)
//   oGnt, oS1, oS0 : one-hot grant and selector select (driven by the arbiter)
//   oZ, oValid     : registered selected data and its valid strobe
//   oBusy          : arbiter holds a grant
interface selector41_rr_arbiter_if;
  import selector41_pkg::*;

  logic [N_REQ-1:0]  iReq;
  logic [DATA_W-1:0] iC0;
  logic [DATA_W-1:0] iC1;
  logic [DATA_W-1:0] iC2;
  logic [DATA_W-1:0] iC3;
  logic [N_REQ-1:0]  oGnt;
  logic              oS1;
  logic              oS0;
  logic [DATA_W-1:0] oZ;
  logic              oValid;
  logic              oBusy;

  // Source side: requesters and the downstream consumer.
  modport master (
    output iReq, iC0, iC1, iC2, iC3,
    input  oGnt, oS1, oS0, oZ, oValid, oBusy
  );

  // Arbiter side.
  modport slave (
    input  iReq, iC0, iC1, iC2, iC3,
    output oGnt, oS1, oS0, oZ, oValid, oBusy
  );
endinterface

// File: rtl/selector41.sv
// Combinational 4-bit 4:1 selector: oZ = iC[{iS1,iS0}].
//   iC0..iC3 : data inputs
//   iS1, iS0 : select MSB/LSB
//   oZ       : selected data
module selector41
  import selector41_pkg::*;
(
  input  logic [DATA_W-1:0] iC0,
  input  logic [DATA_W-1:0] iC1,
  input  logic [DATA_W-1:0] iC2,
  input  logic [DATA_W-1:0] iC3,
  input  logic              iS1,
  input  logic              iS0,
  output logic [DATA_W-1:0] oZ
);

  always_comb begin
    oZ = iC0;
    unique case ({iS1, iS0})
      2'b00: oZ = iC0;
      2'b01: oZ = iC1;
      2'b10: oZ = iC2;
      2'b11: oZ = iC3;
      default: oZ = iC0;
    endcase
  end

endmodule

// File: rtl/selector41_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 selector among four requesters.
//   iClk, iRst : clock, asynchronous active-high reset
//   bus        : slave side of selector41_rr_arbiter_if (requests, data, grant,
//                select, registered data, valid, busy)
// A grant lasts until its requester drops or HOLD_MAX cycles elapse; on release
// the next grantee is picked in the same edge, starting after the old one.
module selector41_rr_arbiter
  import selector41_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                  iClk,
  input  logic                  iRst,
  selector41_rr_arbiter_if.slave bus
);

  arb_state_t        state;
  logic [SEL_W-1:0]  sel;
  logic [SEL_W-1:0]  ptr;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] muxZ;

  logic              reqG;
  logic              release_c;
  logic [SEL_W-1:0]  nextPtr;
  rr_pick_t          pickIdle;
  rr_pick_t          pickRel;

  // Select lines are the grantee index; they hold while idle.
  assign bus.oS1 = sel[1];
  assign bus.oS0 = sel[0];

  selector41 uMux (
    .iC0 (bus.iC0),
    .iC1 (bus.iC1),
    .iC2 (bus.iC2),
    .iC3 (bus.iC3),
    .iS1 (sel[1]),
    .iS0 (sel[0]),
    .oZ  (muxZ)
  );

  // Release decision and both candidate picks (idle scan, post-release scan).
  always_comb begin
    reqG      = bus.iReq[sel];
    release_c = !reqG || (cnt == CNT_W'(HOLD_MAX));
    nextPtr   = sel + SEL_W'(1);
    pickIdle  = rrPick(ptr, bus.iReq);
    pickRel   = rrPick(nextPtr, bus.iReq);
  end

  // Arbitration FSM with registered grant, data and status outputs.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state      <= IDLE;
      sel        <= '0;
      ptr        <= '0;
      cnt        <= '0;
      bus.oGnt   <= '0;
      bus.oZ     <= '0;
      bus.oValid <= 1'b0;
      bus.oBusy  <= 1'b0;
    end else begin
      bus.oValid <= (state == GRANT) && reqG;
      if ((state == GRANT) && reqG) begin
        bus.oZ <= muxZ;
      end

      unique case (state)
        IDLE: begin
          if (pickIdle.found) begin
            state     <= GRANT;
            bus.oBusy <= 1'b1;
            sel       <= pickIdle.idx;
            bus.oGnt  <= oneHot(pickIdle.idx);
            cnt       <= CNT_W'(1);
          end
        end
        GRANT: begin
          if (release_c) begin
            ptr <= nextPtr;
            if (pickRel.found) begin
              sel      <= pickRel.idx;
              bus.oGnt <= oneHot(pickRel.idx);
              cnt      <= CNT_W'(1);
            end else begin
              state     <= IDLE;
              bus.oBusy <= 1'b0;
              bus.oGnt  <= '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_selector41_rr_arbiter.sv
// Scoreboard bench for selector41_rr_arbiter: a behavioural model pushes the
// expected outputs of each cycle when inputs are driven; they are popped and
// compared after the edge. Directed checks cover the named scenarios.
module tb_selector41_rr_arbiter;

  localparam int unsigned HOLD = 4;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] s;
    logic [3:0] z;
    logic       valid;
    logic       busy;
  } exp_t;

  logic iClk;
  logic iRst;
  selector41_rr_arbiter_if bus ();

  selector41_rr_arbiter #(.HOLD_MAX(HOLD), .CNT_W(4)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int   nChecks = 0;
  int   nErrors = 0;
  exp_t expQ[$];

  // Model state
  logic       mBusy;
  logic [1:0] mS;
  logic [1:0] mPtr;
  int         mCnt;
  logic [3:0] mGnt;
  logic [3:0] mZ;
  logic       mValid;

  task automatic checkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mBusy = 1'b0; mS = 2'd0; mPtr = 2'd0; mCnt = 0;
    mGnt = 4'd0; mZ = 4'd0; mValid = 1'b0;
  endtask

  // Entered and left at a falling edge. Drives inputs, predicts, compares after the edge.
  task automatic step(input logic [3:0] req, input logic [3:0] c0, input logic [3:0] c1,
                      input logic [3:0] c2, input logic [3:0] c3);
    logic [3:0] cData [4];
    logic       reqG, rel, found;
    logic [1:0] start, idx, win;
    exp_t       e, got;
    bus.iReq = req; bus.iC0 = c0; bus.iC1 = c1; bus.iC2 = c2; bus.iC3 = c3;
    cData[0] = c0; cData[1] = c1; cData[2] = c2; cData[3] = c3;

    reqG = req[mS];
    e.valid = mBusy && reqG;
    e.z     = (mBusy && reqG) ? cData[mS] : mZ;
    rel     = mBusy && (!reqG || (mCnt == int'(HOLD)));
    e.gnt = mGnt; e.s = mS; e.busy = mBusy;
    if (!mBusy || rel) begin
      start = mBusy ? 2'(mS + 2'd1) : mPtr;
      if (rel) mPtr = start;
      found = 1'b0; win = 2'd0;
      for (int k = 0; k < 4; k++) begin
        idx = 2'(start + 2'(k));
        if (!found && req[idx]) begin
          found = 1'b1; win = idx;
        end
      end
      if (found) begin
        e.busy = 1'b1; e.s = win; e.gnt = 4'(1) << win; mCnt = 1;
      end else begin
        e.busy = 1'b0; e.gnt = 4'd0;
      end
    end else begin
      mCnt++;
    end
    expQ.push_back(e);

    @(posedge iClk);
    #1;
    got = {bus.oGnt, bus.oS1, bus.oS0, bus.oZ, bus.oValid, bus.oBusy};
    e = expQ.pop_front();
    checkEq("gnt",   32'(got.gnt),   32'(e.gnt));
    checkEq("sel",   32'(got.s),     32'(e.s));
    checkEq("z",     32'(got.z),     32'(e.z));
    checkEq("valid", 32'(got.valid), 32'(e.valid));
    checkEq("busy",  32'(got.busy),  32'(e.busy));
    mBusy = e.busy; mS = e.s; mGnt = e.gnt; mZ = e.z; mValid = e.valid;
    @(negedge iClk);
  endtask

  // Entered at a falling edge: reset asserted mid-clock, outputs must clear at once.
  task automatic doReset(input string tag);
    iRst = 1'b1;
    bus.iReq = 4'd0;
    #1;
    checkEq({tag, "_gnt"},   32'(bus.oGnt),   32'd0);
    checkEq({tag, "_valid"}, 32'(bus.oValid), 32'd0);
    checkEq({tag, "_z"},     32'(bus.oZ),     32'd0);
    checkEq({tag, "_busy"},  32'(bus.oBusy),  32'd0);
    modelReset();
    @(negedge iClk);
    iRst = 1'b0;
  endtask

  initial begin
    iRst = 1'b0;
    bus.iReq = 4'd0; bus.iC0 = 4'h0; bus.iC1 = 4'h0; bus.iC2 = 4'h0; bus.iC3 = 4'h0;
    modelReset();
    @(negedge iClk);
    doReset("rst0");
    checkEq("rst0_sel", 32'({bus.oS1, bus.oS0}), 32'd0);

    // Single requester 2, regranted back-to-back every HOLD cycles.
    for (int k = 1; k <= 10; k++) begin
      step(4'b0100, 4'h1, 4'h2, 4'hA, 4'h3);
      if (k == 1) begin
        checkEq("single_gnt1", 32'(bus.oGnt), 32'b0100);
        checkEq("single_sel1", 32'({bus.oS1, bus.oS0}), 32'b10);
        checkEq("single_val1", 32'(bus.oValid), 32'd0);
      end
      if (k >= 2) begin
        checkEq("single_valid", 32'(bus.oValid), 32'd1);
        checkEq("single_z", 32'(bus.oZ), 32'hA);
        checkEq("single_gnt", 32'(bus.oGnt), 32'b0100);
      end
    end

    // Go idle: sole grantee drops; oZ holds the last value.
    step(4'b0000, 4'h1, 4'h2, 4'h5, 4'h3);
    checkEq("idle_gnt", 32'(bus.oGnt), 32'd0);
    checkEq("idle_busy", 32'(bus.oBusy), 32'd0);
    step(4'b0000, 4'h1, 4'h2, 4'h5, 4'h3);
    checkEq("idle_valid", 32'(bus.oValid), 32'd0);
    checkEq("idle_zhold", 32'(bus.oZ), 32'hA);

    // Fairness: all requesting from reset, each tenure exactly HOLD cycles.
    doReset("rst1");
    for (int k = 1; k <= 20; k++) begin
      step(4'b1111, 4'(k), 4'(k + 5), 4'(k + 9), 4'(k + 13));
      checkEq("fair_gnt", 32'(bus.oGnt), 32'(4'(1) << (((k - 1) / int'(HOLD)) % 4)));
    end

    // Early release: grantee 1 drops after 2 granted cycles while 2 requests.
    doReset("rst2");
    step(4'b0110, 4'h0, 4'h7, 4'h9, 4'h0);
    step(4'b0110, 4'h0, 4'h7, 4'h9, 4'h0);
    checkEq("early_gnt1", 32'(bus.oGnt), 32'b0010);
    step(4'b0100, 4'h0, 4'h7, 4'h9, 4'h0);
    checkEq("early_gnt2", 32'(bus.oGnt), 32'b0100);
    checkEq("early_gap", 32'(bus.oValid), 32'd0);
    step(4'b0100, 4'h0, 4'h7, 4'h9, 4'h0);
    checkEq("early_val", 32'(bus.oValid), 32'd1);
    checkEq("early_z", 32'(bus.oZ), 32'h9);

    // Reset mid-tenure with grantee 3, then ptr restarts at 0.
    doReset("rst3");
    step(4'b1000, 4'h0, 4'h0, 4'h0, 4'hC);
    step(4'b1000, 4'h0, 4'h0, 4'h0, 4'hC);
    checkEq("mid_gnt3", 32'(bus.oGnt), 32'b1000);
    doReset("rstmid");
    step(4'b1010, 4'h0, 4'h6, 4'h0, 4'hC);
    checkEq("mid_restart", 32'(bus.oGnt), 32'b0010);

    // Random traffic against the model.
    for (int k = 0; k < 300; k++) begin
      step(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
